nis_cpu_uart_cpu_cpu_debug_mem_arbiter: RTL and testbench
=========================================================

Name: nis_cpu_uart_cpu_cpu_debug_mem_arbiter

Overview:
- Shares the single-port OCI debug memory (monitor ROM/RAM plus debug register bank) between two requesters: the JTAG debug-slave command path (sysclk-side take_action pulses) and the CPU-side Avalon debug_mem_slave port.
- Sequences each access through a fixed-latency read pipeline and returns the data to the requester that owns it.
- Sits between the debug slave sysclk logic, the CPU's debug_mem_slave Avalon interface and the OCI RAM.

Parameters:
ADDR_W, 8, word address width into OCI memory
RD_LAT, 2, memory read latency in clocks (1..3)
JTAG_WR_NEEDS_ACK, 1, when 1, JTAG writes are accepted only while debugack=1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
debugack  in  1  CPU is in debug mode
jtag_cmd_valid  in  1  single-cycle command pulse from the JTAG sysclk path; cannot be stalled
jtag_cmd_write  in  1  1=write, 0=read
jtag_cmd_addr  in  ADDR_W  word address
jtag_cmd_wdata  in  32  write data
jtag_rsp_valid  out  1  one-cycle pulse on JTAG completion (reads and writes)
jtag_rsp_rdata  out  32  read data, held until the next JTAG response
jtag_overflow  out  1  sticky: a JTAG command was lost; cleared by jtag_ovf_clr
jtag_ovf_clr  in  1  clears jtag_overflow
jtag_wr_rejected  out  1  one-cycle pulse when a write is dropped because debugack=0
av_address  in  ADDR_W  Avalon word address
av_read  in  1  Avalon read
av_write  in  1  Avalon write
av_writedata  in  32  Avalon write data
av_byteenable  in  4  Avalon byte enables
av_waitrequest  out  1  Avalon stall
av_readdata  out  32  valid in the cycle av_waitrequest falls on a read
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write strobe
mem_be  out  4  memory byte enables
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, RD_LAT cycles after the address

Behaviour:
- Reset values: all outputs 0 except av_waitrequest=1. The pending JTAG slot is empty, the FSM is in IDLE and last_grant=AV.
- JTAG capture: jtag_cmd_valid loads a 1-deep pending slot.
  - If the slot is already full, or the FSM is serving JTAG, the new command is discarded and jtag_overflow sets.
  - If jtag_ovf_clr and an overflow occur in the same cycle, set wins.
- Write gating: with JTAG_WR_NEEDS_ACK=1, a JTAG write arriving while debugack=0 is not captured. Instead, jtag_wr_rejected pulses and jtag_rsp_valid pulses in the next cycle.
- Avalon request: av_read|av_write is a request held until av_waitrequest=0. av_read and av_write together are treated as a write.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE -> ISSUE when either request is pending. If both are pending, grant the requester that is not last_grant (round-robin), then update last_grant.
  - ISSUE (1 cycle): drive mem_addr. For a write, drive mem_we=1, mem_wdata and mem_be; JTAG writes use be=4'hF. A write then goes to DONE; a read goes to WAIT, loading cnt=RD_LAT-1.
  - WAIT: decrement cnt. When cnt==0, capture mem_rdata and go to DONE. With RD_LAT=1, WAIT lasts exactly 1 cycle.
  - DONE (1 cycle):
    - Avalon grant: av_waitrequest=0, and av_readdata holds the captured data.
    - JTAG grant: jtag_rsp_valid=1, jtag_rsp_rdata updated on reads only, and the pending slot is freed.
    - Next state is IDLE.
- Latency, request visible to completion, with no contention: read = 2+RD_LAT cycles, write = 2 cycles.
- mem_we is asserted only in ISSUE. mem_addr is held stable from ISSUE through the end of WAIT.
- Avalon requests deasserted mid-transaction (protocol violation) do not abort the access; the result is discarded.
- Asynchronous reset mid-transaction aborts to IDLE with no response and clears the pending slot and overflow.
- A new JTAG command may be captured in the DONE cycle of a JTAG grant, because the slot frees in the same edge.

Decomposition:
- Shared package nis_cpu_uart_cpu_debug_pkg: state enum (IDLE/ISSUE/WAIT/DONE), requester id enum (REQ_AV, REQ_JTAG) and the JTAG full-word byte-enable constant.
- One sub-module, nis_cpu_uart_cpu_debug_jtag_cmd_slot: the 1-deep pending slot with the overflow and reject logic.

Test Plan:
- Avalon read, addr 8'h10, memory holding 32'hDEADBEEF, RD_LAT=2 -> av_waitrequest low exactly 4 cycles after the request, with av_readdata=32'hDEADBEEF; mem_we never asserted.
- JTAG write addr 8'h05, data 32'h12345678, debugack=1 -> mem_we for one cycle with be=4'hF; jtag_rsp_valid pulses 2 cycles later; a JTAG read of 8'h05 returns 32'h12345678.
- Avalon and JTAG reads requested in the same cycle after reset -> JTAG served first (last_grant=AV), then Avalon. A second simultaneous pair grants Avalon first.
- Two JTAG pulses 1 cycle apart while an Avalon read is in progress -> the first is served after it, the second is lost and jtag_overflow=1; jtag_ovf_clr returns it to 0.
- JTAG write with debugack=0 -> jtag_wr_rejected pulse, no mem_we, and jtag_rsp_valid the next cycle.
- Assert reset during WAIT of an Avalon read -> av_waitrequest=1, all other outputs 0; after release, the Avalon read is re-served normally.

Source files
------------

// File: rtl/nis_cpu_uart_cpu_debug_pkg.sv
`default_nettype none
// ============================================================================
// nis_cpu_uart_cpu_debug_pkg
// Shared types for the OCI debug memory arbiter and its JTAG command slot.
// Revision: 1.0
// ============================================================================
package nis_cpu_uart_cpu_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_AV   = 1'b0,
    REQ_JTAG = 1'b1
  } req_e;

  // JTAG accesses always cover the full 32-bit word.
  localparam logic [3:0] JTAG_BE = 4'hF;

  // Wide enough for RD_LAT-1 with RD_LAT up to 3.
  localparam int CNT_W = 2;

endpackage
`default_nettype wire

// File: rtl/nis_cpu_uart_cpu_debug_jtag_cmd_slot.sv
`default_nettype none
// ============================================================================
// nis_cpu_uart_cpu_debug_jtag_cmd_slot
// One-deep holding slot for JTAG commands, with sticky overflow and
// write-rejection (debugack=0) signalling.
// Revision: 1.0
// ============================================================================
module nis_cpu_uart_cpu_debug_jtag_cmd_slot #(
  parameter int ADDR_W    = 8,
  parameter bit NEEDS_ACK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [31:0]       i_cmd_wdata,
  input  logic              i_debugack,
  input  logic              i_ovf_clr,
  input  logic              i_slot_free,
  output logic              o_full,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_wdata,
  output logic              o_overflow,
  output logic              o_wr_rejected,
  output logic              o_rej_rsp
);

  logic              r_full;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_overflow;
  logic              r_rej;
  logic              r_rej_rsp;

  logic w_reject;
  logic w_room;
  logic w_capture;
  logic w_lost;

  // A slot being released this cycle can be refilled on the same edge.
  assign w_reject  = i_cmd_valid && i_cmd_write && NEEDS_ACK && !i_debugack;
  assign w_room    = !r_full || i_slot_free;
  assign w_capture = i_cmd_valid && !w_reject && w_room;
  assign w_lost    = i_cmd_valid && !w_reject && !w_room;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full     <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_overflow <= 1'b0;
      r_rej      <= 1'b0;
      r_rej_rsp  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_full  <= 1'b1;
        r_write <= i_cmd_write;
        r_addr  <= i_cmd_addr;
        r_wdata <= i_cmd_wdata;
      end else if (i_slot_free) begin
        r_full <= 1'b0;
      end

      if (w_lost) begin
        r_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
      end

      r_rej     <= w_reject;
      r_rej_rsp <= r_rej;
    end
  end

  assign o_full        = r_full;
  assign o_write       = r_write;
  assign o_addr        = r_addr;
  assign o_wdata       = r_wdata;
  assign o_overflow    = r_overflow;
  assign o_wr_rejected = r_rej;
  assign o_rej_rsp     = r_rej_rsp;

endmodule
`default_nettype wire

// File: rtl/nis_cpu_uart_cpu_cpu_debug_mem_arbiter.sv
`default_nettype none
// ============================================================================
// nis_cpu_uart_cpu_cpu_debug_mem_arbiter
// Round-robin arbiter sharing the single-port OCI debug memory between the
// JTAG command path and the CPU Avalon debug_mem_slave port.
// Revision: 1.0
// ============================================================================
module nis_cpu_uart_cpu_cpu_debug_mem_arbiter
  import nis_cpu_uart_cpu_debug_pkg::*;
#(
  parameter int ADDR_W            = 8,
  parameter int RD_LAT            = 2,
  parameter bit JTAG_WR_NEEDS_ACK = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              debugack,
  input  logic              jtag_cmd_valid,
  input  logic              jtag_cmd_write,
  input  logic [ADDR_W-1:0] jtag_cmd_addr,
  input  logic [31:0]       jtag_cmd_wdata,
  output logic              jtag_rsp_valid,
  output logic [31:0]       jtag_rsp_rdata,
  output logic              jtag_overflow,
  input  logic              jtag_ovf_clr,
  output logic              jtag_wr_rejected,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic              av_waitrequest,
  output logic [31:0]       av_readdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  req_e              r_grant;
  req_e              r_last_grant;
  req_e              w_pick;
  logic              w_start;
  logic              w_contend;

  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_rdata;
  logic [31:0]       r_jtag_rdata;

  logic              w_av_req;
  logic              w_slot_full;
  logic              w_slot_write;
  logic [ADDR_W-1:0] w_slot_addr;
  logic [31:0]       w_slot_wdata;
  logic              w_slot_free;
  logic              w_rej_rsp;

  assign w_av_req    = av_read | av_write;
  assign w_slot_free = (r_state == ST_DONE) && (r_grant == REQ_JTAG);

  nis_cpu_uart_cpu_debug_jtag_cmd_slot #(
    .ADDR_W    (ADDR_W),
    .NEEDS_ACK (JTAG_WR_NEEDS_ACK)
  ) u_jtag_slot (
    .clk           (clk),
    .rst           (reset),
    .i_cmd_valid   (jtag_cmd_valid),
    .i_cmd_write   (jtag_cmd_write),
    .i_cmd_addr    (jtag_cmd_addr),
    .i_cmd_wdata   (jtag_cmd_wdata),
    .i_debugack    (debugack),
    .i_ovf_clr     (jtag_ovf_clr),
    .i_slot_free   (w_slot_free),
    .o_full        (w_slot_full),
    .o_write       (w_slot_write),
    .o_addr        (w_slot_addr),
    .o_wdata       (w_slot_wdata),
    .o_overflow    (jtag_overflow),
    .o_wr_rejected (jtag_wr_rejected),
    .o_rej_rsp     (w_rej_rsp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_start        = 1'b0;
    w_contend      = 1'b0;
    w_pick         = r_grant;
    mem_addr       = '0;
    mem_we         = 1'b0;
    mem_be         = '0;
    mem_wdata      = '0;
    av_waitrequest = 1'b1;
    av_readdata    = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_av_req || w_slot_full) begin
          w_start     = 1'b1;
          w_contend   = w_av_req && w_slot_full;
          w_state_nxt = ST_ISSUE;
          if (w_contend) begin
            w_pick = (r_last_grant == REQ_AV) ? REQ_JTAG : REQ_AV;
          end else begin
            w_pick = w_slot_full ? REQ_JTAG : REQ_AV;
          end
        end
      end
      ST_ISSUE: begin
        mem_addr = r_addr;
        if (r_write) begin
          mem_we      = 1'b1;
          mem_be      = r_be;
          mem_wdata   = r_wdata;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem_addr = r_addr;
        if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        // An Avalon master that dropped its request mid-access gets nothing.
        if (r_grant == REQ_AV && w_av_req) begin
          av_waitrequest = 1'b0;
          if (!r_write) begin
            av_readdata = r_rdata;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant      <= REQ_AV;
      r_last_grant <= REQ_AV;
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_cnt        <= '0;
      r_rdata      <= '0;
      r_jtag_rdata <= '0;
    end else begin
      if (w_start) begin
        r_grant <= w_pick;
        // Fairness pointer only moves when both sides actually competed.
        if (w_contend) begin
          r_last_grant <= w_pick;
        end
        if (w_pick == REQ_JTAG) begin
          r_addr  <= w_slot_addr;
          r_write <= w_slot_write;
          r_wdata <= w_slot_wdata;
          r_be    <= JTAG_BE;
        end else begin
          r_addr  <= av_address;
          r_write <= av_write;
          r_wdata <= av_writedata;
          r_be    <= av_byteenable;
        end
      end

      if (r_state == ST_ISSUE) begin
        r_cnt <= CNT_W'(RD_LAT - 1);
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (r_state == ST_WAIT && r_cnt == '0) begin
        r_rdata <= mem_rdata;
        if (r_grant == REQ_JTAG) begin
          r_jtag_rdata <= mem_rdata;
        end
      end
    end
  end

  assign jtag_rsp_valid = w_slot_free | w_rej_rsp;
  assign jtag_rsp_rdata = r_jtag_rdata;

endmodule
`default_nettype wire

// File: tb/tb_nis_cpu_uart_cpu_cpu_debug_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_nis_cpu_uart_cpu_cpu_debug_mem_arbiter
// Scenario tasks plus randomized traffic against a reference memory.
// Revision: 1.0
// ============================================================================
module tb_nis_cpu_uart_cpu_cpu_debug_mem_arbiter;

  localparam int ADDR_W = 8;
  localparam int RD_LAT = 2;
  localparam int RD_CYC = 2 + RD_LAT;
  localparam int WR_CYC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        debugack;
  logic        jtag_cmd_valid, jtag_cmd_write;
  logic [7:0]  jtag_cmd_addr;
  logic [31:0] jtag_cmd_wdata;
  logic        jtag_rsp_valid;
  logic [31:0] jtag_rsp_rdata;
  logic        jtag_overflow, jtag_ovf_clr, jtag_wr_rejected;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] pipe    [0:RD_LAT-1];
  logic [31:0] ref_mem [0:255];

  always #5 clk = ~clk;

  nis_cpu_uart_cpu_cpu_debug_mem_arbiter #(
    .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .JTAG_WR_NEEDS_ACK(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .debugack(debugack),
    .jtag_cmd_valid(jtag_cmd_valid), .jtag_cmd_write(jtag_cmd_write),
    .jtag_cmd_addr(jtag_cmd_addr), .jtag_cmd_wdata(jtag_cmd_wdata),
    .jtag_rsp_valid(jtag_rsp_valid), .jtag_rsp_rdata(jtag_rsp_rdata),
    .jtag_overflow(jtag_overflow), .jtag_ovf_clr(jtag_ovf_clr),
    .jtag_wr_rejected(jtag_wr_rejected),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // OCI RAM: byte-enabled writes, RD_LAT-cycle registered read path.
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      we_cnt <= we_cnt + 1;
    end
    pipe[0] <= mem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Tasks start and end at the drive point (1ns after a rising edge).
  task automatic av_xact(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output int lat);
    av_address = a; av_write = wr; av_read = !wr; av_writedata = wd; av_byteenable = be;
    lat = 0;
    #1;
    while (av_waitrequest && lat < 50) begin @(posedge clk); #2; lat++; end
    rd = av_readdata;
    @(posedge clk); #1;
    av_read = 1'b0; av_write = 1'b0;
  endtask

  task automatic jt_xact(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat);
    jtag_cmd_write = wr; jtag_cmd_addr = a; jtag_cmd_wdata = wd; jtag_cmd_valid = 1'b1;
    @(posedge clk); #1;
    jtag_cmd_valid = 1'b0;
    lat = 0;
    #1;
    while (!jtag_rsp_valid && lat < 50) begin @(posedge clk); #2; lat++; end
    rd = jtag_rsp_rdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; debugack = 1'b1;
    jtag_cmd_valid = 0; jtag_cmd_write = 0; jtag_cmd_addr = 0; jtag_cmd_wdata = 0;
    jtag_ovf_clr = 0; av_address = 0; av_read = 0; av_write = 0;
    av_writedata = 0; av_byteenable = 0;
    #2;
    n_tests++;
    if (av_waitrequest !== 1'b1) begin
      n_fail++; $display("FAIL reset_waitreq: got %b expected 1", av_waitrequest);
    end
    n_tests++;
    if ({jtag_rsp_valid, jtag_overflow, jtag_wr_rejected, mem_we, mem_be, mem_addr,
         mem_wdata, jtag_rsp_rdata, av_readdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero (we=%b addr=%h rsp=%b) expected 0",
                         mem_we, mem_addr, jtag_rsp_valid);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_tests++;
    if (av_waitrequest !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got wait=%b we=%b expected 1/0", av_waitrequest, mem_we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_av_read();
    logic [31:0] rd; int lat; int we0;
    av_xact(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd, lat);
    ref_mem[8'h10] = 32'hDEADBEEF;
    n_tests++;
    if (lat !== WR_CYC) begin n_fail++; $display("FAIL av_write_lat: got %0d expected %0d", lat, WR_CYC); end
    we0 = we_cnt;
    av_xact(1'b0, 8'h10, 32'h0, 4'hF, rd, lat);
    n_tests++;
    if (lat !== RD_CYC) begin n_fail++; $display("FAIL av_read_lat: got %0d expected %0d", lat, RD_CYC); end
    n_tests++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL av_read_data: got %h expected deadbeef", rd); end
    n_tests++;
    if (we_cnt !== we0) begin n_fail++; $display("FAIL av_read_no_we: got %0d writes expected 0", we_cnt - we0); end
  endtask

  task automatic test_jtag_write_read();
    logic [31:0] rd; int lat;
    debugack = 1'b1;
    jtag_cmd_write = 1'b1; jtag_cmd_addr = 8'h05; jtag_cmd_wdata = 32'h12345678; jtag_cmd_valid = 1'b1;
    @(posedge clk); #1;
    jtag_cmd_valid = 1'b0; jtag_cmd_write = 1'b0;
    #1;
    n_tests++;
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL jtag_we_early: got %b expected 0", mem_we); end
    @(posedge clk); #2;
    n_tests++;
    if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'hF, 8'h05, 32'h12345678}) begin
      n_fail++; $display("FAIL jtag_issue: got we=%b be=%h a=%h d=%h expected 1/f/05/12345678",
                         mem_we, mem_be, mem_addr, mem_wdata);
    end
    n_tests++;
    if (jtag_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL jtag_rsp_early: got %b expected 0", jtag_rsp_valid); end
    @(posedge clk); #2;
    n_tests++;
    if (jtag_rsp_valid !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL jtag_wr_rsp: got rsp=%b we=%b expected 1/0", jtag_rsp_valid, mem_we);
    end
    ref_mem[8'h05] = 32'h12345678;
    @(posedge clk); #1;
    jt_xact(1'b0, 8'h05, 32'h0, rd, lat);
    n_tests++;
    if (lat !== RD_CYC) begin n_fail++; $display("FAIL jtag_read_lat: got %0d expected %0d", lat, RD_CYC); end
    n_tests++;
    if (rd !== 32'h12345678) begin n_fail++; $display("FAIL jtag_read_data: got %h expected 12345678", rd); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      int tj, ta, exp_j, exp_a;
      logic [31:0] dj, da;
      tj = -1; ta = -1; dj = '0; da = '0;
      // Requests collide one cycle after the pulse; the winner alternates.
      exp_j = (p == 0) ? 1 + RD_CYC : 2 + 2*RD_CYC;
      exp_a = (p == 0) ? 2 + 2*RD_CYC : 1 + RD_CYC;
      jtag_cmd_write = 1'b0; jtag_cmd_addr = 8'h05; jtag_cmd_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
        if (c == 1) begin jtag_cmd_valid = 1'b0; av_address = 8'h10; av_read = 1'b1; end
        if (ta >= 0) av_read = 1'b0;
        #1;
        if (jtag_rsp_valid && tj < 0) begin tj = c; dj = jtag_rsp_rdata; end
        if (av_read && !av_waitrequest && ta < 0) begin ta = c; da = av_readdata; end
        @(posedge clk); #1;
      end
      n_tests++;
      if (tj !== exp_j) begin n_fail++; $display("FAIL rr%0d_jtag_cycle: got %0d expected %0d", p, tj, exp_j); end
      n_tests++;
      if (ta !== exp_a) begin n_fail++; $display("FAIL rr%0d_av_cycle: got %0d expected %0d", p, ta, exp_a); end
      n_tests++;
      if (dj !== ref_mem[8'h05] || da !== ref_mem[8'h10]) begin
        n_fail++; $display("FAIL rr%0d_data: got %h/%h expected %h/%h", p, dj, da, ref_mem[8'h05], ref_mem[8'h10]);
      end
    end
  endtask

  task automatic test_overflow();
    int tj, ta, nrsp;
    logic ovf3;
    logic [31:0] dj;
    tj = -1; ta = -1; nrsp = 0; ovf3 = 1'b0; dj = '0;
    for (int c = 0; c < 15; c++) begin
      if (c == 0) begin av_address = 8'h10; av_read = 1'b1; end
      if (c == 1) begin jtag_cmd_write = 1'b0; jtag_cmd_addr = 8'h05; jtag_cmd_valid = 1'b1; end
      if (c == 2) begin jtag_cmd_addr = 8'h07; jtag_ovf_clr = 1'b1; end
      if (c == 3) begin jtag_cmd_valid = 1'b0; jtag_ovf_clr = 1'b0; end
      if (ta >= 0) av_read = 1'b0;
      #1;
      if (c == 3) ovf3 = jtag_overflow;
      if (jtag_rsp_valid) begin nrsp++; tj = c; dj = jtag_rsp_rdata; end
      if (av_read && !av_waitrequest && ta < 0) ta = c;
      @(posedge clk); #1;
    end
    n_tests++;
    if (ta !== RD_CYC) begin n_fail++; $display("FAIL ovf_av_cycle: got %0d expected %0d", ta, RD_CYC); end
    n_tests++;
    if (ovf3 !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b expected 1", ovf3); end
    n_tests++;
    if (nrsp !== 1 || tj !== 2*RD_CYC + 1) begin
      n_fail++; $display("FAIL ovf_jtag_rsp: got %0d rsp at %0d expected 1 at %0d", nrsp, tj, 2*RD_CYC + 1);
    end
    n_tests++;
    if (dj !== ref_mem[8'h05]) begin n_fail++; $display("FAIL ovf_jtag_data: got %h expected %h", dj, ref_mem[8'h05]); end
    jtag_ovf_clr = 1'b1;
    @(posedge clk); #1;
    jtag_ovf_clr = 1'b0;
    #1;
    n_tests++;
    if (jtag_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", jtag_overflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_wr_reject();
    int we0;
    we0 = we_cnt;
    debugack = 1'b0;
    jtag_cmd_write = 1'b1; jtag_cmd_addr = 8'h09; jtag_cmd_wdata = 32'hA5A5A5A5; jtag_cmd_valid = 1'b1;
    @(posedge clk); #1;
    jtag_cmd_valid = 1'b0; jtag_cmd_write = 1'b0;
    #1;
    n_tests++;
    if (jtag_wr_rejected !== 1'b1 || jtag_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rej_pulse: got rej=%b rsp=%b expected 1/0", jtag_wr_rejected, jtag_rsp_valid);
    end
    @(posedge clk); #2;
    n_tests++;
    if (jtag_wr_rejected !== 1'b0 || jtag_rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL rej_rsp: got rej=%b rsp=%b expected 0/1", jtag_wr_rejected, jtag_rsp_valid);
    end
    @(posedge clk); #2;
    n_tests++;
    if (jtag_rsp_valid !== 1'b0 || we_cnt !== we0 || jtag_overflow !== 1'b0) begin
      n_fail++; $display("FAIL rej_quiet: got rsp=%b writes=%0d ovf=%b expected 0/0/0",
                         jtag_rsp_valid, we_cnt - we0, jtag_overflow);
    end
    @(posedge clk); #1;
    debugack = 1'b1;
  endtask

  task automatic test_reset_mid();
    int ta, nrsp;
    logic [31:0] da;
    av_address = 8'h10; av_read = 1'b1;
    jtag_cmd_write = 1'b0; jtag_cmd_addr = 8'h05; jtag_cmd_valid = 1'b1;
    @(posedge clk); #1;
    jtag_cmd_addr = 8'h06;
    @(posedge clk); #1;
    jtag_cmd_valid = 1'b0;
    #1;
    n_tests++;
    if (jtag_overflow !== 1'b1 || mem_addr !== 8'h10) begin
      n_fail++; $display("FAIL mid_pre: got ovf=%b addr=%h expected 1/10", jtag_overflow, mem_addr);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (av_waitrequest !== 1'b1 || {jtag_rsp_valid, jtag_overflow, jtag_wr_rejected, mem_we, mem_be,
        mem_addr, mem_wdata, jtag_rsp_rdata, av_readdata} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got wait=%b ovf=%b addr=%h expected 1/0/00",
                         av_waitrequest, jtag_overflow, mem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ta = -1; nrsp = 0; da = '0;
    for (int c = 0; c < 12; c++) begin
      if (ta >= 0) av_read = 1'b0;
      #1;
      if (av_read && !av_waitrequest && ta < 0) begin ta = c; da = av_readdata; end
      if (jtag_rsp_valid) nrsp++;
      @(posedge clk); #1;
    end
    av_read = 1'b0;
    n_tests++;
    if (ta !== RD_CYC || da !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL mid_reserve: got cycle %0d data %h expected %0d deadbeef", ta, da, RD_CYC);
    end
    n_tests++;
    if (nrsp !== 0 || jtag_overflow !== 1'b0) begin
      n_fail++; $display("FAIL mid_slot_cleared: got rsp=%0d ovf=%b expected 0/0", nrsp, jtag_overflow);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd; logic [7:0] a; logic [3:0] be;
    int lat, kind, n_wr, we0;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      a = 8'(i);
      av_xact(1'b1, a, wd, 4'hF, rd, lat);
      ref_mem[a] = wd;
    end
    n_wr = 0; we0 = we_cnt;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a    = 8'($urandom_range(0, 15));
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      n_tests++;
      case (kind)
        0: begin
          av_xact(1'b0, a, 32'h0, 4'hF, rd, lat);
          if (lat !== RD_CYC || rd !== ref_mem[a]) begin
            n_fail++; $display("FAIL rnd%0d_av_rd a=%h: got lat %0d data %h expected %0d %h", i, a, lat, rd, RD_CYC, ref_mem[a]);
          end
        end
        1: begin
          av_xact(1'b1, a, wd, be, rd, lat);
          for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
          n_wr++;
          if (lat !== WR_CYC) begin n_fail++; $display("FAIL rnd%0d_av_wr: got lat %0d expected %0d", i, lat, WR_CYC); end
        end
        2: begin
          jt_xact(1'b0, a, 32'h0, rd, lat);
          if (lat !== RD_CYC || rd !== ref_mem[a]) begin
            n_fail++; $display("FAIL rnd%0d_jt_rd a=%h: got lat %0d data %h expected %0d %h", i, a, lat, rd, RD_CYC, ref_mem[a]);
          end
        end
        default: begin
          jt_xact(1'b1, a, wd, rd, lat);
          ref_mem[a] = wd;
          n_wr++;
          if (lat !== WR_CYC) begin n_fail++; $display("FAIL rnd%0d_jt_wr: got lat %0d expected %0d", i, lat, WR_CYC); end
        end
      endcase
    end
    n_tests++;
    if (we_cnt - we0 !== n_wr) begin
      n_fail++; $display("FAIL rnd_we_count: got %0d expected %0d", we_cnt - we0, n_wr);
    end
  endtask

  initial begin
    test_reset();
    test_av_read();
    test_jtag_write_read();
    test_round_robin();
    test_overflow();
    test_wr_reject();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
